// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM request/response controller:
// FSM state encoding, access-size codes and the lane extension helper.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mc_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Widen a byte or halfword lane to 32 bits, sign- or zero-extended.
  function automatic logic [31:0] ext_lane(input logic [15:0] v,
                                           input logic        is_half,
                                           input logic        sgn);
    logic [31:0] r;
    if (is_half) begin
      r = sgn ? {{16{v[15]}}, v} : {16'h0000, v};
    end else begin
      r = sgn ? {{24{v[7]}}, v[7:0]} : {24'h000000, v[7:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Combinational byte-lane steering: store-side select and replication,
// alignment check, and load-side lane extraction with extension.
module sram_lane_align
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the SRAM word.
  always_comb begin
    byte_s = rdata[{addr_lo, 3'b000} +: 8];
    half_s = rdata[{addr_lo[1], 4'b0000} +: 16];
  end

  // Decode lane select, replicated store data, legality and load result.
  always_comb begin
    sel       = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    rdata_ext = rdata;
    case (size)
      SIZE_BYTE: begin
        sel       = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = ext_lane({8'h00, byte_s}, 1'b0, sgn);
      end
      SIZE_HALF: begin
        sel       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
        rdata_ext = ext_lane(half_s, 1'b1, sgn);
      end
      SIZE_WORD: begin
        sel       = 4'b1111;
        misalign  = (addr_lo != 2'b00);
      end
      default: begin
        // reserved size is always rejected
        sel       = 4'b0000;
        misalign  = 1'b1;
        rdata_ext = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// Request/response front-end for a single-port word SRAM with a one-cycle
// read latency. Accepts one load/store at a time, rejects misaligned or
// reserved-size requests without touching the SRAM.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_sel,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  mc_state_e   state_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic [1:0]  addr_lo_r;
  logic        we_r;

  logic [1:0]  al_size_s;
  logic        al_sgn_s;
  logic [1:0]  al_addr_lo_s;
  logic [3:0]  sel_s;
  logic [31:0] wdata_rep_s;
  logic        misalign_s;
  logic [31:0] rdata_ext_s;

  assign req_ready = (state_r == ST_IDLE);

  // In IDLE the aligner looks at the live request; afterwards at the
  // attributes captured at accept, so the requester may move on.
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_size_s    = req_size;
      al_sgn_s     = req_signed;
      al_addr_lo_s = req_addr[1:0];
    end else begin
      al_size_s    = size_r;
      al_sgn_s     = signed_r;
      al_addr_lo_s = addr_lo_r;
    end
  end

  sram_lane_align u_align (
    .size      (al_size_s),
    .sgn       (al_sgn_s),
    .addr_lo   (al_addr_lo_s),
    .wdata     (req_wdata),
    .rdata     (sram_rdata),
    .sel       (sel_s),
    .wdata_rep (wdata_rep_s),
    .misalign  (misalign_s),
    .rdata_ext (rdata_ext_s)
  );

  // Controller FSM with all SRAM and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      addr_lo_r  <= 2'b00;
      we_r       <= 1'b0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_sel   <= 4'b0000;
      sram_wdata <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            size_r    <= req_size;
            signed_r  <= req_signed;
            addr_lo_r <= req_addr[1:0];
            we_r      <= req_we;
            if (misalign_s) begin
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state_r    <= ST_ISSUE;
              sram_ce    <= 1'b1;
              sram_we    <= req_we;
              sram_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              // the SRAM ignores select on reads; drive all lanes
              sram_sel   <= req_we ? sel_s : 4'b1111;
              sram_wdata <= wdata_rep_s;
            end
          end
        end
        ST_ISSUE: begin
          sram_ce <= 1'b0;
          sram_we <= 1'b0;
          if (we_r) begin
            state_r   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state_r   <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= rdata_ext_s;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          sram_ce   <= 1'b0;
          sram_we   <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a behavioural word SRAM.
module tb_sram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sram_ce;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [3:0]  sram_sel;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int errors = 0;
  int checks = 0;

  // observations captured by xact
  int          lat_o;
  logic        ce_seen_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] wd_o;
  logic [31:0] ad_o;
  logic [31:0] rdata_o;
  logic        err_o;

  logic [31:0] mem [0:15];

  sram_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_sel   (sram_sel),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-masked writes, read data valid one cycle after the
  // read edge, filler pattern on every other cycle.
  always @(posedge clk) begin
    if (sram_ce && sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_sel[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= 32'h5A5A_A5A5;
    end else if (sram_ce) begin
      sram_rdata <= mem[sram_addr[5:2]];
    end else begin
      sram_rdata <= 32'h5A5A_A5A5;
    end
  end

  // Issue one request, scramble the request inputs after accept, and
  // record SRAM activity and the response latency (bounded wait).
  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_signed = ~sgn;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h1234_5678;
    lat_o = -1; ce_seen_o = 1'b0; we_o = 1'b0; sel_o = 4'h0;
    wd_o = 32'h0; ad_o = 32'h0; rdata_o = 32'h0; err_o = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (sram_ce) begin
        ce_seen_o = 1'b1; we_o = sram_we; sel_o = sram_sel;
        wd_o = sram_wdata; ad_o = sram_addr;
      end
      if (rsp_valid) begin
        lat_o = i; rdata_o = rsp_rdata; err_o = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (sram_ce !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b want 0", sram_ce); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    checks++; if (lat_o !== 2) begin errors++; $display("FAIL st_word_lat: got %0d want 2", lat_o); end
    checks++; if (sel_o !== 4'b1111) begin errors++; $display("FAIL st_word_sel: got %b want 1111", sel_o); end
    checks++; if (ad_o !== 32'h10) begin errors++; $display("FAIL st_word_addr: got %h want 10", ad_o); end
    checks++; if (we_o !== 1'b1) begin errors++; $display("FAIL st_word_we: got %b want 1", we_o); end
    checks++; if (wd_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_word_wdata: got %h want deadbeef", wd_o); end
    checks++; if ({err_o, rdata_o} !== 33'h0) begin errors++; $display("FAIL st_word_rsp: got err=%b rdata=%h want 0/0", err_o, rdata_o); end
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (lat_o !== 3) begin errors++; $display("FAIL ld_word_lat: got %0d want 3", lat_o); end
    checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL ld_word_we: got %b want 0", we_o); end
    checks++; if (sel_o !== 4'b1111) begin errors++; $display("FAIL ld_word_sel: got %b want 1111", sel_o); end
    checks++; if (rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_word_data: got %h want deadbeef", rdata_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ld_word_err: got %b want 0", err_o); end
  endtask

  task automatic test_byte();
    xact(1'b1, 2'b00, 1'b1, 32'h13, 32'h1234_5680);
    checks++; if (sel_o !== 4'b1000) begin errors++; $display("FAIL st_byte_sel: got %b want 1000", sel_o); end
    checks++; if (wd_o !== 32'h8080_8080) begin errors++; $display("FAIL st_byte_wdata: got %h want 80808080", wd_o); end
    checks++; if (ad_o !== 32'h10) begin errors++; $display("FAIL st_byte_addr: got %h want 10", ad_o); end
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checks++; if (rdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL ld_byte_s: got %h want ffffff80", rdata_o); end
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    checks++; if (rdata_o !== 32'h0000_0080) begin errors++; $display("FAIL ld_byte_u: got %h want 00000080", rdata_o); end
    xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    checks++; if (rdata_o !== 32'h0000_00BE) begin errors++; $display("FAIL ld_byte_lane1: got %h want 000000be", rdata_o); end
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (rdata_o !== 32'h80AD_BEEF) begin errors++; $display("FAIL ld_word_merge: got %h want 80adbeef", rdata_o); end
  endtask

  task automatic test_half();
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_7FFF);
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    checks++; if (rdata_o !== 32'hFFFF_8001) begin errors++; $display("FAIL ld_half_s_hi: got %h want ffff8001", rdata_o); end
    xact(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    checks++; if (rdata_o !== 32'h0000_7FFF) begin errors++; $display("FAIL ld_half_s_lo: got %h want 00007fff", rdata_o); end
    xact(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    checks++; if (rdata_o !== 32'h0000_8001) begin errors++; $display("FAIL ld_half_u_hi: got %h want 00008001", rdata_o); end
    xact(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_A5C3);
    checks++; if (sel_o !== 4'b1100) begin errors++; $display("FAIL st_half_sel: got %b want 1100", sel_o); end
    checks++; if (wd_o !== 32'hA5C3_A5C3) begin errors++; $display("FAIL st_half_wdata: got %h want a5c3a5c3", wd_o); end
    checks++; if (ad_o !== 32'h14) begin errors++; $display("FAIL st_half_addr: got %h want 14", ad_o); end
  endtask

  task automatic test_errors();
    xact(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
    checks++; if (lat_o !== 1) begin errors++; $display("FAIL err_word_lat: got %0d want 1", lat_o); end
    checks++; if ({err_o, rdata_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL err_word_rsp: got err=%b rdata=%h want 1/0", err_o, rdata_o); end
    checks++; if (ce_seen_o !== 1'b0) begin errors++; $display("FAIL err_word_ce: got %b want 0", ce_seen_o); end
    xact(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF);
    checks++; if (lat_o !== 1) begin errors++; $display("FAIL err_rsvd_lat: got %0d want 1", lat_o); end
    checks++; if ({err_o, rdata_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL err_rsvd_rsp: got err=%b rdata=%h want 1/0", err_o, rdata_o); end
    checks++; if (ce_seen_o !== 1'b0) begin errors++; $display("FAIL err_rsvd_ce: got %b want 0", ce_seen_o); end
    xact(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_half: got %b want 1", err_o); end
    // memory must be unchanged by the rejected store
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (rdata_o !== 32'h8001_7FFF) begin errors++; $display("FAIL err_no_write: got %h want 80017fff", rdata_o); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (rdata_o !== 32'h8001_7FFF) begin errors++; $display("FAIL bp_first: got %h want 80017fff", rdata_o); end
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h1111_1111; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_rdata, req_ready} !== {1'b1, 32'h8001_7FFF, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b want 1/80017fff/0", i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (rdata_o !== 32'h8001_7FFF) begin errors++; $display("FAIL bp_not_accepted: got %h want 80017fff", rdata_o); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++; if (sram_ce !== 1'b1) begin errors++; $display("FAIL mid_issue_ce: got %b want 1", sram_ce); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({sram_ce, sram_we, rsp_valid} !== 3'b000) begin errors++; $display("FAIL mid_async: got ce=%b we=%b v=%b want 0/0/0", sram_ce, sram_we, rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL mid_after[%0d]: got v=%b rdy=%b want 0/1", i, rsp_valid, req_ready); end
    end
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if ({lat_o == 3, rdata_o} !== {1'b1, 32'h8001_7FFF}) begin errors++; $display("FAIL mid_recover: got lat=%0d d=%h want 3/80017fff", lat_o, rdata_o); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
